// File: rtl/x_dac_player_pkg.sv
// x_dac_player_pkg: shared types and helpers for the DAC sample player.
package x_dac_player_pkg;

   // Playback controller states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Thermometer code width for a binary sample of the given width
   function automatic int therm_width(input int bits);
      return 32'sd1 << bits;
   endfunction

endpackage

// File: rtl/x_dac_player_therm_enc.sv
// x_therm_enc: registered binary-to-thermometer stage for one DAC channel.
// Holds its output unless told to load a new sample or to clear.
module x_therm_enc
   import x_dac_player_pkg::*;
#(
   parameter int p_bits = 6
) (
   input  logic                          i_clk,
   input  logic                          i_nrst,
   input  logic                          i_load,
   input  logic                          i_clr,
   input  logic [p_bits-1:0]             i_bin,
   output logic [therm_width(p_bits)-1:0] o_therm
);

   localparam int T = therm_width(p_bits);

   logic [T-1:0] r_therm;
   logic [T-1:0] w_therm;

   // Value b lights bits [b-1:0]; the top bit can never be set
   function automatic logic [T-1:0] bin2therm(input logic [p_bits-1:0] b);
      logic [T-1:0] v;
      v = {T{1'b0}};
      for (int i = 0; i < T; i++) begin
         v[i] = (i < int'(b)) ? 1'b1 : 1'b0;
      end
      return v;
   endfunction

   // Next output: load wins over clear, otherwise hold
   always_comb begin
      w_therm = r_therm;
      if (i_load) begin
         w_therm = bin2therm(i_bin);
      end else if (i_clr) begin
         w_therm = {T{1'b0}};
      end else begin
         w_therm = r_therm;
      end
   end

   // Output register
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_therm <= {T{1'b0}};
      end else begin
         r_therm <= w_therm;
      end
   end

   assign o_therm = r_therm;

endmodule

// File: rtl/x_dac_player.sv
// x_dac_player: multi-channel DAC sample player. A sample table is played
// from address 0 to a captured last address with a programmable dwell,
// optionally looping, and each channel is driven as a registered
// thermometer code two cycles behind the play address.
// Build option: X_DAC_PLAYER_IDLE_ZERO_EN forces the codes to zero once the
// pipeline drains after playback ends; otherwise the last sample is held.
module x_dac_player
   import x_dac_player_pkg::*;
#(
   parameter int p_channels = 1,
   parameter int p_bits     = 6,
   parameter int p_depth    = 2048,
   parameter int p_div_w    = 16
) (
   input  logic                                       i_clk,
   input  logic                                       i_nrst,
   input  logic                                       i_wr_valid,
   input  logic [$clog2(p_depth)-1:0]                 i_wr_addr,
   input  logic [p_channels*p_bits-1:0]               i_wr_data,
   input  logic                                       i_start,
   input  logic                                       i_stop,
   input  logic                                       i_loop,
   input  logic [$clog2(p_depth)-1:0]                 i_last_addr,
   input  logic [p_div_w-1:0]                         i_div,
   output logic                                       o_busy,
   output logic                                       o_done,
   output logic [$clog2(p_depth)-1:0]                 o_addr,
   output logic [p_channels*therm_width(p_bits)-1:0]  o_code
);

   localparam int AW = $clog2(p_depth);
   localparam int DW = p_channels * p_bits;
   localparam int T  = therm_width(p_bits);

   localparam logic [AW-1:0]      lp_addr_zero = AW'(0);
   localparam logic [AW-1:0]      lp_addr_one  = AW'(1);
   localparam logic [p_div_w-1:0] lp_cnt_zero  = p_div_w'(0);
   localparam logic [p_div_w-1:0] lp_cnt_one   = p_div_w'(1);

   logic [DW-1:0]      r_mem [0:p_depth-1];
   logic [DW-1:0]      r_rd_data;
   logic               r_rd_vld;

   state_t             r_state;
   logic [AW-1:0]      r_addr;
   logic [p_div_w-1:0] r_cnt;
   logic [p_div_w-1:0] r_div;
   logic [AW-1:0]      r_last;
   logic               r_done;

   state_t             w_state_nx;
   logic [AW-1:0]      w_addr_nx;
   logic [p_div_w-1:0] w_cnt_nx;
   logic [p_div_w-1:0] w_div_nx;
   logic [AW-1:0]      w_last_nx;
   logic               w_done_nx;
   logic               w_enc_load;
   logic               w_enc_clr;

   // Table write port; contents are intentionally left unreset
   always_ff @(posedge i_clk) begin
      if (i_wr_valid) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Registered read of the current play address; valid tracks RUN one cycle later
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_rd_data <= {DW{1'b0}};
         r_rd_vld  <= 1'b0;
      end else begin
         r_rd_data <= r_mem[r_addr];
         r_rd_vld  <= (r_state == ST_RUN);
      end
   end

   // Next-state logic: start/stop handling, dwell divider and address stepping
   always_comb begin
      w_state_nx = r_state;
      w_addr_nx  = r_addr;
      w_cnt_nx   = r_cnt;
      w_div_nx   = r_div;
      w_last_nx  = r_last;
      w_done_nx  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start && !i_stop) begin
               w_state_nx = ST_RUN;
               w_div_nx   = i_div;
               w_last_nx  = i_last_addr;
               w_addr_nx  = lp_addr_zero;
               w_cnt_nx   = lp_cnt_zero;
            end else begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (i_stop) begin
               // Abort beats a coincident tick; address is frozen, no done pulse
               w_state_nx = ST_IDLE;
            end else if (r_cnt == r_div) begin
               w_cnt_nx = lp_cnt_zero;
               if (r_addr < r_last) begin
                  w_addr_nx = r_addr + lp_addr_one;
               end else if (i_loop) begin
                  w_addr_nx = lp_addr_zero;
               end else begin
                  w_state_nx = ST_IDLE;
                  w_done_nx  = 1'b1;
               end
            end else begin
               w_cnt_nx = r_cnt + lp_cnt_one;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // Controller state register
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_state <= ST_IDLE;
         r_addr  <= lp_addr_zero;
         r_cnt   <= lp_cnt_zero;
         r_div   <= lp_cnt_zero;
         r_last  <= lp_addr_zero;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_addr  <= w_addr_nx;
         r_cnt   <= w_cnt_nx;
         r_div   <= w_div_nx;
         r_last  <= w_last_nx;
         r_done  <= w_done_nx;
      end
   end

   // Encoder control: load while read data belongs to playback, clear per build option
   always_comb begin
      w_enc_load = r_rd_vld;
`ifdef X_DAC_PLAYER_IDLE_ZERO_EN
      w_enc_clr  = ~r_rd_vld;
`else
      w_enc_clr  = 1'b0;
`endif
   end

   // One thermometer stage per channel
   for (genvar c = 0; c < p_channels; c++) begin : g_chan
      x_therm_enc #(
         .p_bits (p_bits)
      ) u_enc (
         .i_clk   (i_clk),
         .i_nrst  (i_nrst),
         .i_load  (w_enc_load),
         .i_clr   (w_enc_clr),
         .i_bin   (r_rd_data[c*p_bits +: p_bits]),
         .o_therm (o_code[c*T +: T])
      );
   end

   assign o_busy = (r_state == ST_RUN);
   assign o_done = r_done;
   assign o_addr = r_addr;

endmodule
